// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: streaming multiply-accumulate. It accepts one unsigned
// N-bit operand pair per cycle over valid/ready, registers the pair, multiplies it
// and sums every LEN consecutive products into one ACC_W-bit result. Each result
// carries a sticky overflow flag.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is combinational
//   in_a, in_b          N-bit unsigned operands
//   out_valid/out_ready registered result handshake
//   out_sum             sum of LEN products, modulo 2^ACC_W
//   out_ovf             some addition in this result carried out of ACC_W bits
module dot_product_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 2*N + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned IDX_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned PROD_W = 2*N;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    // Occupancy of stage 1 and the output register.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_HOLD,
        ST_STALL
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               v1_q, v1_d;
    logic               last_q, last_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [PROD_W-1:0]  prod_c;
    logic [SUM_W-1:0]   sum_c;
    logic               stall_c;
    logic               xfer_c;
    logic               fire_c;

    n_bit_multiplier #(
        .N (N)
    ) u_mult (
        .a (a_q),
        .b (b_q),
        .p (prod_c)
    );

    // STALL means a last element waits behind a full output register; it only
    // blocks while the consumer is not taking the result this cycle.
    assign stall_c   = (state_q == ST_STALL) && !out_ready;
    assign in_ready  = !rst && !stall_c;
    assign xfer_c    = in_valid && in_ready;
    assign fire_c    = v1_q && !stall_c;
    assign sum_c     = {1'b0, acc_q} + SUM_W'(prod_c);

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            idx_q       <= '0;
            v1_q        <= 1'b0;
            last_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            v1_q        <= v1_d;
            last_q      <= last_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Next-state: stage-1 load, accumulate/emit, output handshake, occupancy.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        v1_d        = v1_q;
        last_d      = last_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (xfer_c) begin
            a_d    = in_a;
            b_d    = in_b;
            v1_d   = 1'b1;
            last_d = (idx_q == IDX_LAST);
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else if (fire_c) begin
            v1_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A new result overrides the consume-clear above.
        if (fire_c) begin
            if (last_q) begin
                out_sum_d   = sum_c[ACC_W-1:0];
                out_ovf_d   = ovf_q | sum_c[ACC_W];
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum_c[ACC_W-1:0];
                ovf_d = ovf_q | sum_c[ACC_W];
            end
        end

        if (!out_valid_d) begin
            state_d = v1_d ? ST_FILL : ST_EMPTY;
        end else if (v1_d && last_d) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_HOLD;
        end
    end

endmodule

// n_bit_multiplier: combinational unsigned N x N -> 2N multiplier.
module n_bit_multiplier #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    assign p = (2*N)'(a) * (2*N)'(b);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: two instances (ACC_W=10 and ACC_W=8) share
// the stimulus; a per-width arithmetic model predicts every result.
module tb_dot_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_ready;

    logic       in_ready10, out_valid10, out_ovf10;
    logic [9:0] out_sum10;
    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_sum8;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;

    // Model state: index 0 -> ACC_W=10, index 1 -> ACC_W=8.
    int acc_m [2];
    bit ovf_m [2];
    int cnt_m [2];
    int exp_sum [2][$];
    bit exp_ovf [2][$];

    bit b2b_on = 1'b0;
    int b2b_q[$];

    always #5 clk = ~clk;

    dot_product_accumulator #(.N(4), .LEN(4), .ACC_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready10),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid10),
        .out_ready (out_ready),
        .out_sum   (out_sum10),
        .out_ovf   (out_ovf10)
    );

    dot_product_accumulator #(.N(4), .LEN(4), .ACC_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_sum   (out_sum8),
        .out_ovf   (out_ovf8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            ovf_m[k] = 1'b0;
            cnt_m[k] = 0;
            exp_sum[k].delete();
            exp_ovf[k].delete();
        end
    endtask

    // Add one product; every 4th product closes a vector.
    task automatic model_add(input int k, input int prod);
        int modv;
        modv = (k == 0) ? 1024 : 256;
        acc_m[k] = acc_m[k] + prod;
        if (acc_m[k] >= modv) begin
            acc_m[k] = acc_m[k] - modv;
            ovf_m[k] = 1'b1;
        end
        cnt_m[k]++;
        if (cnt_m[k] == 4) begin
            exp_sum[k].push_back(acc_m[k]);
            exp_ovf[k].push_back(ovf_m[k]);
            acc_m[k] = 0;
            ovf_m[k] = 1'b0;
            cnt_m[k] = 0;
        end
    endtask

    task automatic consume(input int k, input logic [63:0] sum, input logic ovf);
        chk(k == 0 ? "res10_expected" : "res8_expected", 64'(exp_sum[k].size() != 0), 64'd1);
        if (exp_sum[k].size() != 0) begin
            chk(k == 0 ? "sum10" : "sum8", sum, 64'(exp_sum[k].pop_front()));
            chk(k == 0 ? "ovf10" : "ovf8", 64'(ovf), 64'(exp_ovf[k].pop_front()));
        end
    endtask

    // One clock: observe handshakes at negedge, then return #1 after posedge.
    task automatic cycle(output bit xf);
        int prod;
        @(negedge clk);
        xf = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            prod = int'(in_a) * int'(in_b);
            if (out_valid10 && out_ready) consume(0, 64'(out_sum10), out_ovf10);
            if (out_valid8 && out_ready)  consume(1, 64'(out_sum8), out_ovf8);
            if (in_valid && in_ready10) begin
                model_add(0, prod);
                xf = 1'b1;
            end
            if (in_valid && in_ready8) model_add(1, prod);
            if (b2b_on && out_valid10 && out_ready) b2b_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit xf;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(xf);
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, output int tries);
        bit xf;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tries    = 0;
        xf       = 1'b0;
        while (!xf && tries < 20) begin
            cycle(xf);
            tries++;
        end
        chk("send_accepted", 64'(xf), 64'd1);
    endtask

    initial begin
        int t;
        bit xf;
        logic [3:0] va [4];
        logic [3:0] vb [4];
        int v2sum;
        logic [3:0] basic_a [4] = '{4'd3, 4'd2, 4'd15, 4'd1};
        logic [3:0] basic_b [4] = '{4'd5, 4'd7, 4'd15, 4'd1};
        logic [3:0] gap_a [4]   = '{4'd0, 4'd15, 4'd8, 4'd2};
        logic [3:0] gap_b [4]   = '{4'd9, 4'd0, 4'd8, 4'd3};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        model_reset();

        // Reset state
        cycle(xf);
        chk("rst_in_ready", 64'(in_ready10), 64'd0);
        chk("rst_out_valid", 64'(out_valid10), 64'd0);
        chk("rst_out_sum", 64'(out_sum10), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf10), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready10), 64'd1);

        // Basic vector with one-cycle latency
        for (int i = 0; i < 4; i++) send(basic_a[i], basic_b[i], t);
        in_valid = 1'b0;
        chk("basic_not_yet", 64'(out_valid10), 64'd0);
        cycle(xf);
        chk("basic_valid", 64'(out_valid10), 64'd1);
        chk("basic_sum", 64'(out_sum10), 64'd255);
        chk("basic_ovf", 64'(out_ovf10), 64'd0);
        idle(2);

        // Overflow in the 8-bit instance, then a clean vector
        for (int i = 0; i < 4; i++) send(4'd15, 4'd15, t);
        in_valid = 1'b0;
        cycle(xf);
        chk("ovf_sum8", 64'(out_sum8), 64'd132);
        chk("ovf_flag8", 64'(out_ovf8), 64'd1);
        chk("ovf_sum10", 64'(out_sum10), 64'd900);
        chk("ovf_flag10", 64'(out_ovf10), 64'd0);
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1, t);
        in_valid = 1'b0;
        cycle(xf);
        chk("clean_sum8", 64'(out_sum8), 64'd4);
        chk("clean_ovf8", 64'(out_ovf8), 64'd0);
        idle(2);

        // Backpressure: two vectors with out_ready low
        out_ready = 1'b0;
        v2sum = 0;
        for (int i = 0; i < 4; i++) begin
            va[i] = 4'($urandom);
            vb[i] = 4'($urandom);
            v2sum = v2sum + int'(va[i]) * int'(vb[i]);
        end
        for (int i = 0; i < 4; i++) send(basic_a[i], basic_b[i], t);
        for (int i = 0; i < 4; i++) send(va[i], vb[i], t);
        chk("bp_in_ready_low", 64'(in_ready10), 64'd0);
        chk("bp_hold_sum", 64'(out_sum10), 64'd255);
        idle(3);
        chk("bp_still_low", 64'(in_ready10), 64'd0);
        chk("bp_still_valid", 64'(out_valid10), 64'd1);
        chk("bp_still_sum", 64'(out_sum10), 64'd255);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready10), 64'd1);
        cycle(xf);
        out_ready = 1'b0;
        #1;
        chk("bp_second_valid", 64'(out_valid10), 64'd1);
        chk("bp_second_sum", 64'(out_sum10), 64'(v2sum % 1024));
        chk("bp_ready_after", 64'(in_ready10), 64'd1);
        out_ready = 1'b1;
        idle(2);
        chk("bp_drained", 64'(out_valid10), 64'd0);

        // Back-to-back: 12 pairs, no bubbles, results 4 cycles apart
        b2b_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(4'($urandom), 4'($urandom), t);
            chk("b2b_one_cycle", 64'(t), 64'd1);
        end
        idle(2);
        b2b_on = 1'b0;
        chk("b2b_results", 64'(b2b_q.size()), 64'd3);
        if (b2b_q.size() == 3) begin
            chk("b2b_gap1", 64'(b2b_q[1] - b2b_q[0]), 64'd4);
            chk("b2b_gap2", 64'(b2b_q[2] - b2b_q[1]), 64'd4);
        end

        // Reset mid-vector with a pending result
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(4'($urandom), 4'($urandom), t);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle(xf);
        chk("mid_rst_in_ready", 64'(in_ready10), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid10), 64'd0);
        chk("mid_rst_sum", 64'(out_sum10), 64'd0);
        chk("mid_rst_ovf", 64'(out_ovf10), 64'd0);
        chk("mid_rst_ready", 64'(in_ready10), 64'd1);
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1, t);
        in_valid = 1'b0;
        cycle(xf);
        chk("mid_rst_result", 64'(out_sum10), 64'd4);
        idle(2);

        // Idle gaps between pairs
        for (int i = 0; i < 4; i++) begin
            send(gap_a[i], gap_b[i], t);
            idle(3);
        end
        chk("gap_result_seen", 64'(exp_sum[0].size()), 64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            out_ready = ($urandom_range(2) != 0);
            cycle(xf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("drain_valid", 64'(out_valid10), 64'd0);
        chk("drain_q10", 64'(exp_sum[0].size()), 64'd0);
        chk("drain_q8", 64'(exp_sum[1].size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
